sfifo_ram_mq_pkt_desc: RTL and testbench

Multi-queue synchronous descriptor FIFO. NUM_Q logical queues are statically partitioned in one block RAM.
- Each queue gets 2^DEPTH_NBITS entries; RAM address is {qid, ptr}.
- One write port and one read port, each steered by a queue ID. Registered read data carries a valid and the queue ID.
- Successor to the single-queue descriptor FIFO. Sits between the enqueue classifier and the per-class scheduler.

---
 rtl/sfifo_ram_mq_pkt_desc_pkg.sv | 22 ++
 rtl/sfifo_mq_qctrl.sv | 72 +++++++
 rtl/sfifo_ram_mq_pkt_desc.sv | 112 +++++++++++
 tb/tb_sfifo_ram_mq_pkt_desc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_ram_mq_pkt_desc_pkg.sv
// Shared types and defaults for the multi-queue descriptor FIFO.
// Also provides the default name of the reset port (RESET_SIG macro).
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

package meta_package;

  typedef struct packed {
    logic [11:0] buf_ptr;
    logic [13:0] pkt_len;
    logic [5:0]  src_port;
    logic [2:0]  cls;
    logic        eop;
  } enq_pkt_desc_type;

  localparam int SFIFO_MQ_DEF_DEPTH_NBITS = 10;
  localparam int SFIFO_MQ_DEF_NUM_Q_NBITS = 3;

  typedef logic [SFIFO_MQ_DEF_NUM_Q_NBITS-1:0] mq_qid_type;

endpackage

// File: rtl/sfifo_mq_qctrl.sv
// Per-queue control: write/read pointers, occupancy count, registered flags.
// Ports: clk, reset (RESET_SIG macro), push, pop, [pfull_thresh when
// SFIFO_MQ_PFULL_EN], wptr, rptr, cnt, full, empty, pfull.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module sfifo_mq_qctrl
  import meta_package::*;
#(
  parameter int DEPTH_NBITS = SFIFO_MQ_DEF_DEPTH_NBITS
) (
  input  logic                   clk,
  input  logic                   `RESET_SIG,
  input  logic                   push,
  input  logic                   pop,
`ifdef SFIFO_MQ_PFULL_EN
  input  logic [DEPTH_NBITS:0]   pfull_thresh,
`endif
  output logic [DEPTH_NBITS-1:0] wptr,
  output logic [DEPTH_NBITS-1:0] rptr,
  output logic [DEPTH_NBITS:0]   cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   pfull
);

  localparam logic [DEPTH_NBITS:0] CAP =
    {1'b1, {DEPTH_NBITS{1'b0}}};
  localparam logic [DEPTH_NBITS:0] CNT_ONE =
    {{DEPTH_NBITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_NBITS-1:0] PTR_ONE =
    {{(DEPTH_NBITS-1){1'b0}}, 1'b1};

  logic [DEPTH_NBITS:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_ONE;
      2'b01:   cnt_next = cnt - CNT_ONE;
      default: cnt_next = cnt;
    endcase
  end

  // Flags come from cnt_next so they are valid with the new count.
  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      cnt   <= cnt_next;
      full  <= (cnt_next == CAP);
      empty <= (cnt_next == '0);
    end
  end

`ifdef SFIFO_MQ_PFULL_EN
  always_ff @(posedge clk) begin
    if (`RESET_SIG) pfull <= 1'b0;
    else            pfull <= (cnt_next >= pfull_thresh);
  end
`else
  assign pfull = full;
`endif

endmodule

// File: rtl/sfifo_ram_mq_pkt_desc.sv
// Multi-queue descriptor FIFO: NUM_Q queues statically partitioned in one RAM.
// Ports: clk, reset (RESET_SIG macro), wr/wr_qid/din, rd/rd_qid,
// dout/dout_valid/dout_qid, full/empty/pfull/count, ovf_err/udf_err/err_clr,
// pfull_thresh only when SFIFO_MQ_PFULL_EN is defined.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module sfifo_ram_mq_pkt_desc
  import meta_package::*;
#(
  parameter int DATA_NBITS  = $bits(enq_pkt_desc_type),
  parameter int DEPTH_NBITS = SFIFO_MQ_DEF_DEPTH_NBITS,
  parameter int NUM_Q_NBITS = SFIFO_MQ_DEF_NUM_Q_NBITS
) (
  input  logic                     clk,
  input  logic                     `RESET_SIG,
  input  logic                     wr,
  input  logic [NUM_Q_NBITS-1:0]   wr_qid,
  input  logic [DATA_NBITS-1:0]    din,
  input  logic                     rd,
  input  logic [NUM_Q_NBITS-1:0]   rd_qid,
`ifdef SFIFO_MQ_PFULL_EN
  input  logic [DEPTH_NBITS:0]     pfull_thresh,
`endif
  output logic [DATA_NBITS-1:0]    dout,
  output logic                     dout_valid,
  output logic [NUM_Q_NBITS-1:0]   dout_qid,
  output logic [(1<<NUM_Q_NBITS)-1:0] full,
  output logic [(1<<NUM_Q_NBITS)-1:0] empty,
  output logic [(1<<NUM_Q_NBITS)-1:0] pfull,
  output logic [(1<<NUM_Q_NBITS)*(DEPTH_NBITS+1)-1:0] count,
  output logic                     ovf_err,
  output logic                     udf_err,
  input  logic                     err_clr
);

  localparam int NUM_Q = 1 << NUM_Q_NBITS;
  localparam int CW    = DEPTH_NBITS + 1;
  localparam int AW    = NUM_Q_NBITS + DEPTH_NBITS;

  logic [DATA_NBITS-1:0]  mem [1<<AW];
  logic [DEPTH_NBITS-1:0] wptr [NUM_Q];
  logic [DEPTH_NBITS-1:0] rptr [NUM_Q];
  logic [NUM_Q-1:0]       push;
  logic [NUM_Q-1:0]       pop;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          rd_addr;

  // Rejection against current full/empty keeps wr and rd off one address.
  assign wr_acc  = wr & ~full[wr_qid];
  assign rd_acc  = rd & ~empty[rd_qid];
  assign wr_addr = {wr_qid, wptr[wr_qid]};
  assign rd_addr = {rd_qid, rptr[rd_qid]};

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    assign push[q] = wr_acc & (wr_qid == NUM_Q_NBITS'(q));
    assign pop[q]  = rd_acc & (rd_qid == NUM_Q_NBITS'(q));

    sfifo_mq_qctrl #(
      .DEPTH_NBITS (DEPTH_NBITS)
    ) u_qctrl (
      .clk          (clk),
      .`RESET_SIG   (`RESET_SIG),
      .push         (push[q]),
      .pop          (pop[q]),
`ifdef SFIFO_MQ_PFULL_EN
      .pfull_thresh (pfull_thresh),
`endif
      .wptr         (wptr[q]),
      .rptr         (rptr[q]),
      .cnt          (count[q*CW +: CW]),
      .full         (full[q]),
      .empty        (empty[q]),
      .pfull        (pfull[q])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_qid   <= '0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout     <= mem[rd_addr];
        dout_qid <= rd_qid;
      end
    end
  end

  // Sticky errors; a new event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr & full[wr_qid]) ovf_err <= 1'b1;
      else if (err_clr)      ovf_err <= 1'b0;
      if (rd & empty[rd_qid]) udf_err <= 1'b1;
      else if (err_clr)       udf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfifo_ram_mq_pkt_desc.sv
// Directed self-checking bench for sfifo_ram_mq_pkt_desc (default depth 1024,
// 8 queues); pfull checks follow SFIFO_MQ_PFULL_EN.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_sfifo_ram_mq_pkt_desc;
  import meta_package::*;

  localparam int DW = $bits(enq_pkt_desc_type);
  localparam int DN = 10;
  localparam int QN = 3;
  localparam int NQ = 8;
  localparam int CW = DN + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [QN-1:0] wr_qid;
  logic [DW-1:0] din;
  logic          rd;
  logic [QN-1:0] rd_qid;
  logic [DN:0]   pfull_thresh;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [QN-1:0] dout_qid;
  logic [NQ-1:0] full;
  logic [NQ-1:0] empty;
  logic [NQ-1:0] pfull;
  logic [NQ*CW-1:0] count;
  logic          ovf_err;
  logic          udf_err;
  logic          err_clr;

  sfifo_ram_mq_pkt_desc dut (
    .clk          (clk),
    .`RESET_SIG   (rst),
    .wr           (wr),
    .wr_qid       (wr_qid),
    .din          (din),
    .rd           (rd),
    .rd_qid       (rd_qid),
`ifdef SFIFO_MQ_PFULL_EN
    .pfull_thresh (pfull_thresh),
`endif
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_qid     (dout_qid),
    .full         (full),
    .empty        (empty),
    .pfull        (pfull),
    .count        (count),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] qc(input int q);
    return 64'(count[q*CW +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int q, input logic [DW-1:0] d);
    wr = 1'b1; wr_qid = QN'(q); din = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 0; rd = 0; err_clr = 0;
    wr_qid = '0; rd_qid = '0; din = '0;
    pfull_thresh = 11'd8;
    tick(); tick();
    rst = 1'b0;

    check("rst_empty", 64'(empty), 64'hFF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_pfull", 64'(pfull), 64'h0);
    check("rst_cnt0", 64'(count == '0), 64'd1);
    check("rst_dv", 64'(dout_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dqid", 64'(dout_qid), 64'd0);
    check("rst_errs", {62'd0, ovf_err, udf_err}, 64'd0);

    // q2 basic order and latency
    push(2, DW'(4'hA));
    push(2, DW'(4'hB));
    push(2, DW'(4'hC));
    check("q2_cnt3", qc(2), 64'd3);
    check("q2_nempty", 64'(empty[2]), 64'd0);
    rd = 1'b1; rd_qid = 3'd2;
    tick();
    check("q2_d0", 64'(dout), 64'hA);
    check("q2_v0", 64'(dout_valid), 64'd1);
    check("q2_qid", 64'(dout_qid), 64'd2);
    tick();
    check("q2_d1", 64'(dout), 64'hB);
    tick();
    rd = 1'b0;
    check("q2_d2", 64'(dout), 64'hC);
    check("q2_cnt0", qc(2), 64'd0);
    check("q2_empty", 64'(empty[2]), 64'd1);
    tick();
    check("idle_dv", 64'(dout_valid), 64'd0);
    check("idle_hold", 64'(dout), 64'hC);

    // fill q0, then overflow
    for (int i = 0; i < 1024; i++) push(0, DW'(i));
    check("q0_full", 64'(full[0]), 64'd1);
    check("q0_pfull", 64'(pfull[0]), 64'd1);
    check("q0_cnt", qc(0), 64'd1024);
    check("q0_noovf", 64'(ovf_err), 64'd0);
    push(0, DW'(32'hDEAD));
    check("ovf_set", 64'(ovf_err), 64'd1);
    check("ovf_cnt", qc(0), 64'd1024);
    check("q1_cnt", qc(1), 64'd0);
    check("q1_full", 64'(full[1]), 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", 64'(ovf_err), 64'd0);
    rd = 1'b1; rd_qid = 3'd0;
    tick();
    rd = 1'b0;
    check("q0_first", 64'(dout), 64'd0);
    check("q0_cnt1023", qc(0), 64'd1023);
    check("q0_nfull", 64'(full[0]), 64'd0);

    // same-cycle read/write on q5
    for (int i = 0; i < 4; i++) push(5, DW'(8'h50 + i));
    wr = 1'b1; wr_qid = 3'd5; din = DW'(8'h54);
    rd = 1'b1; rd_qid = 3'd5;
    tick();
    check("q5_cnt", qc(5), 64'd4);
    check("q5_dout", 64'(dout), 64'h50);
    check("q5_dv", 64'(dout_valid), 64'd1);
    check("q5_qid", 64'(dout_qid), 64'd5);
    // same-cycle on empty q6: read rejected
    wr_qid = 3'd6; din = DW'(8'h60); rd_qid = 3'd6;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("q6_udf", 64'(udf_err), 64'd1);
    check("q6_cnt", qc(6), 64'd1);
    check("q6_dv", 64'(dout_valid), 64'd0);
    check("q6_hold", 64'(dout), 64'h50);
    // set beats clear
    err_clr = 1'b1; rd = 1'b1; rd_qid = 3'd7;
    tick();
    rd = 1'b0;
    check("udf_setwin", 64'(udf_err), 64'd1);
    tick();
    err_clr = 1'b0;
    check("udf_clr", 64'(udf_err), 64'd0);

    // wrap q7 with 2000 write/read pairs
    for (int k = 0; k < 2000; k++) begin
      wr = 1'b1; wr_qid = 3'd7; din = DW'(32'h7000 + k);
      rd = (k > 0); rd_qid = 3'd7;
      tick();
      if (k > 0) begin
        check("wrap_d", 64'(dout), 64'(32'h7000 + k - 1));
        check("wrap_v", 64'(dout_valid), 64'd1);
      end
    end
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    check("wrap_last", 64'(dout), 64'(32'h7000 + 1999));
    check("wrap_cnt", qc(7), 64'd0);
    check("wrap_errs", {62'd0, ovf_err, udf_err}, 64'd0);

    // reset mid-stream with a read accepted in the reset cycle
    for (int i = 0; i < 10; i++) push(3, DW'(8'h30 + i));
    rd = 1'b1; rd_qid = 3'd3;
    tick();
    check("q3_dv", 64'(dout_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; rd = 1'b0;
    check("mrst_dv", 64'(dout_valid), 64'd0);
    check("mrst_cnt0", 64'(count == '0), 64'd1);
    check("mrst_empty", 64'(empty), 64'hFF);
    check("mrst_full", 64'(full), 64'h0);
    check("mrst_dout", 64'(dout), 64'd0);

    // almost-full on q4, threshold 8
    for (int i = 0; i < 7; i++) push(4, DW'(8'h40 + i));
    check("q4_cnt7", qc(4), 64'd7);
    check("q4_pf7", 64'(pfull[4]), 64'd0);
    push(4, DW'(8'h47));
    check("q4_cnt8", qc(4), 64'd8);
`ifdef SFIFO_MQ_PFULL_EN
    check("q4_pf8", 64'(pfull[4]), 64'd1);
`else
    check("q4_pf8", 64'(pfull), 64'(full));
`endif
    rd = 1'b1; rd_qid = 3'd4;
    tick();
    rd = 1'b0;
    check("q4_pfrd", 64'(pfull[4]), 64'd0);
    check("q4_dout", 64'(dout), 64'h40);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
